// File: rtl/gate_vector_checker.sv
// Clocked stimulus/response checker for a 2-input gate: drives a/b, samples y,
// compares against a truth table. Optional fail_map output under CHECK_FAILMAP_EN.
module gate_vector_checker #(
  parameter logic [3:0]  EXPECTED      = 4'b0001,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned NUM_PASSES    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic [1:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count
`ifdef CHECK_FAILMAP_EN
  ,
  output logic [3:0] fail_map
`endif
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
  localparam logic [5:0] LAST_PASS   = 6'(NUM_PASSES - 1);

  state_t     state;
  logic [3:0] settle_cnt;
  logic [5:0] pass_cnt;
  logic       mismatch;
  logic       last_vec;
  logic [7:0] err_next;

  // The gate inputs are simply the two bits of the registered vector index.
  assign a = vec_idx[1];
  assign b = vec_idx[0];

  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    // Case inequality so an X/Z on y is reported as a mismatch.
    mismatch = (y !== EXPECTED[vec_idx]);
    err_next = err_count;
    if (mismatch && (err_count != 8'hFF)) err_next = err_count + 8'd1;
    last_vec = (vec_idx == 2'd3) && (pass_cnt == LAST_PASS);
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous and clears every register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec_idx    <= 2'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 8'd0;
      settle_cnt <= 4'd0;
      pass_cnt   <= 6'd0;
`ifdef CHECK_FAILMAP_EN
      fail_map   <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= SETTLE;
            vec_idx    <= 2'd0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 8'd0;
            settle_cnt <= SETTLE_LOAD;
            pass_cnt   <= 6'd0;
`ifdef CHECK_FAILMAP_EN
            fail_map   <= 4'd0;
`endif
          end
        end

        SETTLE: begin
          if (settle_cnt <= 4'd1) state <= SAMPLE;
          else                    settle_cnt <= settle_cnt - 4'd1;
        end

        SAMPLE: begin
          err_count <= err_next;
`ifdef CHECK_FAILMAP_EN
          if (mismatch) fail_map[vec_idx] <= 1'b1;
`endif
          if (last_vec) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 8'd0);
          end else begin
            // Wrapping from vector 3 back to 0 closes one full sweep.
            if (vec_idx == 2'd3) pass_cnt <= pass_cnt + 6'd1;
            vec_idx    <= vec_idx + 2'd1;
            settle_cnt <= SETTLE_LOAD;
            state      <= SETTLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Randomised self-checking bench for gate_vector_checker: two instances (1 and 3 sweeps)
// around a programmable "gate" table, checked every cycle against a cycle-count model.
module tb_gate_vector_checker;

  localparam logic [3:0] EXP = 4'b0001;
  localparam int S0 = 2, N0 = 1, S1 = 2, N1 = 3;
  localparam int L0 = 4 * N0 * (S0 + 1);
  localparam int L1 = 4 * N1 * (S1 + 1);

  typedef struct packed {
    logic       a;
    logic       b;
    logic [1:0] v;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err;
    logic [3:0] fmap;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [3:0] g = EXP;
  logic chk_en = 1'b0;

  logic a0, b0, busy0, done0, pass0, y0;
  logic a1, b1, busy1, done1, pass1, y1;
  logic [1:0] v0, v1;
  logic [7:0] e0, e1;
  logic [3:0] fm0, fm1;

  int total = 0;
  int bad = 0;
  int c0 = 0, c1 = 0;
  logic [3:0] gr0 = EXP, gr1 = EXP;

  // The gate under test is whatever truth table g currently holds.
  assign y0 = g[{a0, b0}];
  assign y1 = g[{a1, b1}];

`ifndef CHECK_FAILMAP_EN
  assign fm0 = 4'd0;
  assign fm1 = 4'd0;
`endif

  gate_vector_checker #(.EXPECTED(EXP), .SETTLE_CYCLES(S0), .NUM_PASSES(N0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .y(y0), .a(a0), .b(b0), .vec_idx(v0),
    .busy(busy0), .done(done0), .pass(pass0),
`ifdef CHECK_FAILMAP_EN
    .fail_map(fm0),
`endif
    .err_count(e0));

  gate_vector_checker #(.EXPECTED(EXP), .SETTLE_CYCLES(S1), .NUM_PASSES(N1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .y(y1), .a(a1), .b(b1), .vec_idx(v1),
    .busy(busy1), .done(done1), .pass(pass1),
`ifdef CHECK_FAILMAP_EN
    .fail_map(fm1),
`endif
    .err_count(e1));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // c = cycles since the accepted start edge (0 = idle/reset); each vector costs s+1
  // cycles and its sample is the last of them, so samples before cycle c are vectors 0..m-1.
  function automatic exp_t model(input int s, input int n, input int c, input logic [3:0] gt);
    exp_t r;
    int len, m, errs;
    r = '0;
    errs = 0;
    len = 4 * n * (s + 1);
    if (c == 0) return r;
    m = (c > len) ? 4 * n : (c - 1) / (s + 1);
    for (int i = 0; i < m; i++) begin
      if (gt[i % 4] != EXP[i % 4]) begin
        errs++;
        r.fmap[i % 4] = 1'b1;
      end
    end
    r.v    = (c > len) ? 2'd3 : 2'(m % 4);
    r.a    = r.v[1];
    r.b    = r.v[0];
    r.busy = (c <= len);
    r.done = (c > len);
    r.err  = 8'((errs > 255) ? 255 : errs);
    r.pass = r.done && (errs == 0);
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      c0 <= 0;
      c1 <= 0;
    end else begin
      if (start && (c0 == 0 || c0 > L0)) begin c0 <= 1; gr0 <= g; end
      else if (c0 > 0 && c0 <= L0) c0 <= c0 + 1;
      if (start && (c1 == 0 || c1 > L1)) begin c1 <= 1; gr1 <= g; end
      else if (c1 > 0 && c1 <= L1) c1 <= c1 + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      exp_t x0, x1;
      x0 = model(S0, N0, c0, gr0);
      x1 = model(S1, N1, c1, gr1);
      check("dut0 outputs", {a0, b0, v0, busy0, done0, pass0, e0},
            {x0.a, x0.b, x0.v, x0.busy, x0.done, x0.pass, x0.err});
      check("dut1 outputs", {a1, b1, v1, busy1, done1, pass1, e1},
            {x1.a, x1.b, x1.v, x1.busy, x1.done, x1.pass, x1.err});
`ifdef CHECK_FAILMAP_EN
      check("dut0 fail_map", fm0, x0.fmap);
      check("dut1 fail_map", fm1, x1.fmap);
`endif
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  // Pulse start, optionally poke start again at cycle 'poke', and report the
  // cycle at which each instance first shows done (-1 if the bound expires).
  task automatic run(input int poke, output int k0, output int k1);
    k0 = -1;
    k1 = -1;
    start = 1'b1;
    tick();
    for (int k = 1; k <= 400; k++) begin
      start = (k == poke);
      if (done0 && k0 < 0) k0 = k;
      if (done1 && k1 < 0) k1 = k;
      if (k0 >= 0 && k1 >= 0) break;
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    int k0, k1;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    chk_en = 1'b1;
    check("reset outputs", {a0, b0, v0, busy0, done0, pass0, e0, fm0}, 32'd0);

    g = EXP;
    run(0, k0, k1);
    check("ideal done cycle", k0, 13);
    check("ideal pass/err", {pass0, e0}, {1'b1, 8'd0});
    check("ideal 3-pass done cycle", k1, 37);

    g = 4'b0000;
    run(0, k0, k1);
    check("tied0 err/pass", {pass0, e0}, {1'b0, 8'd1});
    check("tied0 3-pass err", e1, 3);
    check("tied0 3-pass done cycle", k1, 37);
`ifdef CHECK_FAILMAP_EN
    check("tied0 fail_map", fm0, 4'b0001);
`endif

    g = 4'b1111;
    run(0, k0, k1);
    check("tied1 err/pass", {pass0, e0}, {1'b0, 8'd3});
    check("tied1 3-pass err", e1, 9);
`ifdef CHECK_FAILMAP_EN
    check("tied1 fail_map", fm0, 4'b1110);
`endif

    g = EXP;
    run(5, k0, k1);
    check("start while busy done cycle", k0, 13);

    // Restart dut0 from DONE while dut1 is still busy.
    g = 4'b0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    check("done before restart", {done0, e0}, {1'b1, 8'd1});
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart from done", {done0, busy0, e0, busy1, done1}, {1'b0, 1'b1, 8'd0, 1'b1, 1'b0});
    for (int i = 0; i < 100 && !(done0 && done1); i++) tick();
    check("restart completes", {done0, e0, done1, e1}, {1'b1, 8'd1, 1'b1, 8'd3});

    // Reset mid-run at cycle 7.
    g = EXP;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid-run reset", {a0, b0, v0, busy0, done0, pass0, e0, busy1, done1, e1}, 32'd0);
    repeat (40) tick();
    check("no done after reset", {done0, done1, busy0, busy1}, 4'd0);

    for (int it = 0; it < 12; it++) begin
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      g = 4'($urandom);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < int'($urandom_range(60, 5)); k++) begin
        start = ($urandom_range(15) == 0);
        rst_n = ($urandom_range(39) != 0);
        tick();
      end
      start = 1'b0;
      rst_n = 1'b1;
      run(0, k0, k1);
      check("random run finishes", {k0 >= 0, k1 >= 0}, 2'b11);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
